rvh_l1d_mshr_refill_release: RTL and testbench

Refill-return and release side of the L1D MSHR file. It owns the per-entry MSHR valid vector that the MSHR allocator scans for a free entry, and sets a bit when an entry is allocated. It assembles the L2 refill beats for an outstanding miss into a full cache line and hands that line to the data/tag array write path. When the array accepts the line, it frees the entry.

---
 rtl/rvh_l1d_mshr_refill_release_if.sv | 38 +++
 rtl/rvh_l1d_mshr_refill_release.sv | 116 +++++++++++
 tb/tb_rvh_l1d_mshr_refill_release.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rvh_l1d_mshr_refill_release_if.sv
// Handshake bundle between the L1D MSHR refill/release block and its neighbours
// (allocator, L2 refill channel, data/tag array write path).
interface rvh_l1d_mshr_refill_release_if #(
  parameter int unsigned N_MSHR = 4,
  parameter int unsigned LINE_W = 512,
  parameter int unsigned BEAT_W = 128
);
  localparam int unsigned ID_W = (N_MSHR > 1) ? $clog2(N_MSHR) : 1;

  logic              alloc_vld_i;
  logic [ID_W-1:0]   alloc_id_i;
  logic [N_MSHR-1:0] mshr_bank_valid_o;
  logic              refill_beat_vld_i;
  logic [ID_W-1:0]   refill_beat_id_i;
  logic [BEAT_W-1:0] refill_beat_data_i;
  logic              refill_beat_rdy_o;
  logic              line_vld_o;
  logic [ID_W-1:0]   line_id_o;
  logic [LINE_W-1:0] line_data_o;
  logic              line_rdy_i;
  logic              dealloc_vld_o;
  logic [ID_W-1:0]   dealloc_id_o;
  logic              err_o;

  modport master (
    output alloc_vld_i, alloc_id_i, refill_beat_vld_i, refill_beat_id_i,
           refill_beat_data_i, line_rdy_i,
    input  mshr_bank_valid_o, refill_beat_rdy_o, line_vld_o, line_id_o,
           line_data_o, dealloc_vld_o, dealloc_id_o, err_o
  );

  modport slave (
    input  alloc_vld_i, alloc_id_i, refill_beat_vld_i, refill_beat_id_i,
           refill_beat_data_i, line_rdy_i,
    output mshr_bank_valid_o, refill_beat_rdy_o, line_vld_o, line_id_o,
           line_data_o, dealloc_vld_o, dealloc_id_o, err_o
  );
endinterface

// File: rtl/rvh_l1d_mshr_refill_release.sv
// L1D MSHR refill/release: owns the MSHR valid vector, assembles L2 refill
// beats into a line, hands it to the array and frees the entry on acceptance.
module rvh_l1d_mshr_refill_release #(
  parameter int unsigned N_MSHR = 4,
  parameter int unsigned LINE_W = 512,
  parameter int unsigned BEAT_W = 128
) (
  input logic clk,
  input logic rst,
  rvh_l1d_mshr_refill_release_if.slave bus
);
  localparam int unsigned ID_W  = (N_MSHR > 1) ? $clog2(N_MSHR) : 1;
  localparam int unsigned BEATS = LINE_W / BEAT_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, SEND} state_e;

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [ID_W-1:0]               id_q, id_d;
  logic [BEATS-1:0][BEAT_W-1:0]  line_q, line_d;
  logic [N_MSHR-1:0]             valid_q, valid_d;
  logic                          err_q, err_d;
  logic                          dealloc_vld_q, dealloc_vld_d;
  logic [ID_W-1:0]               dealloc_id_q, dealloc_id_d;
  logic                          beat_rdy_q, line_vld_q;
  logic                          beat_hs, line_hs;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      id_q          <= '0;
      line_q        <= '0;
      valid_q       <= '0;
      err_q         <= 1'b0;
      dealloc_vld_q <= 1'b0;
      dealloc_id_q  <= '0;
      beat_rdy_q    <= 1'b1;
      line_vld_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      id_q          <= id_d;
      line_q        <= line_d;
      valid_q       <= valid_d;
      err_q         <= err_d;
      dealloc_vld_q <= dealloc_vld_d;
      dealloc_id_q  <= dealloc_id_d;
      beat_rdy_q    <= (state_d != SEND);
      line_vld_q    <= (state_d == SEND);
    end
  end

  // Next-state, beat assembly, valid-vector update and error detection
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    id_d          = id_q;
    line_d        = line_q;
    valid_d       = valid_q;
    err_d         = err_q;
    dealloc_vld_d = 1'b0;
    dealloc_id_d  = dealloc_id_q;
    beat_hs       = bus.refill_beat_vld_i && beat_rdy_q;
    line_hs       = line_vld_q && bus.line_rdy_i;

    unique case (state_q)
      IDLE: begin
        if (beat_hs) begin
          id_d      = bus.refill_beat_id_i;
          line_d[0] = bus.refill_beat_data_i;
          cnt_d     = CNT_W'(1);
          state_d   = (BEATS == 1) ? SEND : COLLECT;
        end
      end
      COLLECT: begin
        if (beat_hs) begin
          line_d[cnt_q] = bus.refill_beat_data_i;
          cnt_d         = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BEATS - 1)) state_d = SEND;
          // A stray id is stored but never retargets the line
          if (bus.refill_beat_id_i != id_q) err_d = 1'b1;
        end
      end
      SEND: begin
        if (line_hs) begin
          valid_d[id_q] = 1'b0;
          dealloc_vld_d = 1'b1;
          dealloc_id_d  = id_q;
          cnt_d         = '0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (beat_hs && !valid_q[bus.refill_beat_id_i]) err_d = 1'b1;

    // Alloc is applied after release so a same-id collision leaves the entry valid
    if (bus.alloc_vld_i) begin
      if (valid_q[bus.alloc_id_i] && !(line_hs && (id_q == bus.alloc_id_i))) err_d = 1'b1;
      valid_d[bus.alloc_id_i] = 1'b1;
    end
  end

  assign bus.mshr_bank_valid_o = valid_q;
  assign bus.refill_beat_rdy_o = beat_rdy_q;
  assign bus.line_vld_o        = line_vld_q;
  assign bus.line_id_o         = id_q;
  assign bus.line_data_o       = line_q;
  assign bus.dealloc_vld_o     = dealloc_vld_q;
  assign bus.dealloc_id_o      = dealloc_id_q;
  assign bus.err_o             = err_q;
endmodule

// File: tb/tb_rvh_l1d_mshr_refill_release.sv
// Scoreboard bench for the L1D MSHR refill/release block.
module tb_rvh_l1d_mshr_refill_release;
  localparam int unsigned N_MSHR = 4;
  localparam int unsigned LINE_W = 512;
  localparam int unsigned BEAT_W = 128;
  localparam int unsigned BEATS  = LINE_W / BEAT_W;
  localparam int unsigned ID_W   = 2;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [LINE_W-1:0] data;
  } line_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rvh_l1d_mshr_refill_release_if #(.N_MSHR(N_MSHR), .LINE_W(LINE_W), .BEAT_W(BEAT_W)) bus ();

  rvh_l1d_mshr_refill_release #(.N_MSHR(N_MSHR), .LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    n_cmp = 0;
  int    n_err = 0;
  line_t            line_sb[$];
  logic [ID_W-1:0]  dealloc_sb[$];

  task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pop expectations as the DUT hands off lines and pulses dealloc
  always @(negedge clk) begin : monitor
    line_t           e;
    logic [ID_W-1:0] d;
    if (rst) begin
      if (bus.line_vld_o && bus.line_rdy_i) begin
        if (line_sb.size() == 0) check("line_unexpected", bus.line_vld_o, 1'b0);
        else begin
          e = line_sb.pop_front();
          check("line_id", LINE_W'(bus.line_id_o), LINE_W'(e.id));
          check("line_data", bus.line_data_o, e.data);
        end
      end
      if (bus.dealloc_vld_o) begin
        if (dealloc_sb.size() == 0) check("dealloc_unexpected", bus.dealloc_vld_o, 1'b0);
        else begin
          d = dealloc_sb.pop_front();
          check("dealloc_id", LINE_W'(bus.dealloc_id_o), LINE_W'(d));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic alloc(input logic [ID_W-1:0] id);
    bus.alloc_vld_i = 1'b1;
    bus.alloc_id_i  = id;
    step();
    bus.alloc_vld_i = 1'b0;
  endtask

  task automatic beat(input logic [ID_W-1:0] id, input logic [BEAT_W-1:0] d);
    int w;
    w = 0;
    bus.refill_beat_vld_i  = 1'b1;
    bus.refill_beat_id_i   = id;
    bus.refill_beat_data_i = d;
    while (!bus.refill_beat_rdy_o && w < 50) begin
      step();
      w++;
    end
    if (!bus.refill_beat_rdy_o) check("beat_rdy_timeout", LINE_W'(bus.refill_beat_rdy_o), LINE_W'(1));
    step();
    bus.refill_beat_vld_i = 1'b0;
  endtask

  // Expect the line and its release, then send all beats back-to-back
  task automatic refill(input logic [ID_W-1:0] id, input logic [LINE_W-1:0] l);
    line_sb.push_back('{id: id, data: l});
    dealloc_sb.push_back(id);
    for (int k = 0; k < BEATS; k++) beat(id, l[k*BEAT_W +: BEAT_W]);
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [LINE_W-1:0] pattern_line();
    logic [LINE_W-1:0] r;
    logic [3:0]        nib;
    for (int k = 0; k < BEATS; k++) begin
      nib = 4'(k);
      r[k*BEAT_W +: BEAT_W] = {32{nib}};
    end
    return r;
  endfunction

  initial begin
    logic [LINE_W-1:0] la, lb, lc;
    bus.alloc_vld_i        = 1'b0;
    bus.alloc_id_i         = '0;
    bus.refill_beat_vld_i  = 1'b0;
    bus.refill_beat_id_i   = '0;
    bus.refill_beat_data_i = '0;
    bus.line_rdy_i         = 1'b1;
    rst                    = 1'b0;
    do_reset();

    // Reset state
    check("rst_valid", LINE_W'(bus.mshr_bank_valid_o), '0);
    check("rst_line_vld", LINE_W'(bus.line_vld_o), '0);
    check("rst_dealloc", LINE_W'(bus.dealloc_vld_o), '0);
    check("rst_err", LINE_W'(bus.err_o), '0);
    check("rst_beat_rdy", LINE_W'(bus.refill_beat_rdy_o), LINE_W'(1));

    // Alloc id 2
    alloc(2'd2);
    check("alloc_valid", LINE_W'(bus.mshr_bank_valid_o), LINE_W'(4'b0100));
    check("alloc_no_dealloc", LINE_W'(bus.dealloc_vld_o), '0);

    // Basic refill of id 2 with k-pattern beats
    refill(2'd2, pattern_line());
    check("basic_line_vld", LINE_W'(bus.line_vld_o), LINE_W'(1));
    check("basic_beat_rdy", LINE_W'(bus.refill_beat_rdy_o), '0);
    step();
    check("basic_valid_clr", LINE_W'(bus.mshr_bank_valid_o), '0);
    check("basic_dealloc", LINE_W'(bus.dealloc_vld_o), LINE_W'(1));
    check("basic_rdy_back", LINE_W'(bus.refill_beat_rdy_o), LINE_W'(1));
    step();
    check("basic_dealloc_end", LINE_W'(bus.dealloc_vld_o), '0);
    check("basic_err", LINE_W'(bus.err_o), '0);

    // Back-pressure: hold SEND while the next line's first beat waits
    alloc(2'd0);
    alloc(2'd3);
    la = rand_line();
    lb = rand_line();
    bus.line_rdy_i = 1'b0;
    refill(2'd0, la);
    bus.refill_beat_vld_i  = 1'b1;
    bus.refill_beat_id_i   = 2'd3;
    bus.refill_beat_data_i = lb[BEAT_W-1:0];
    for (int i = 0; i < 5; i++) begin
      check("bp_beat_rdy", LINE_W'(bus.refill_beat_rdy_o), '0);
      check("bp_line_vld", LINE_W'(bus.line_vld_o), LINE_W'(1));
      check("bp_line_data", bus.line_data_o, la);
      step();
    end
    bus.line_rdy_i = 1'b1;
    step();
    check("bp_valid", LINE_W'(bus.mshr_bank_valid_o), LINE_W'(4'b1000));
    check("bp_dealloc", LINE_W'(bus.dealloc_vld_o), LINE_W'(1));
    check("bp_rdy_back", LINE_W'(bus.refill_beat_rdy_o), LINE_W'(1));
    refill(2'd3, lb);
    step();
    step();
    check("bp_valid_end", LINE_W'(bus.mshr_bank_valid_o), '0);

    // Same-cycle alloc and release of id 1
    alloc(2'd1);
    bus.line_rdy_i = 1'b0;
    refill(2'd1, rand_line());
    bus.line_rdy_i  = 1'b1;
    bus.alloc_vld_i = 1'b1;
    bus.alloc_id_i  = 2'd1;
    step();
    bus.alloc_vld_i = 1'b0;
    check("same_valid", LINE_W'(bus.mshr_bank_valid_o), LINE_W'(4'b0010));
    check("same_dealloc", LINE_W'(bus.dealloc_vld_o), LINE_W'(1));
    check("same_err", LINE_W'(bus.err_o), '0);
    step();

    // Error: beat for an invalid id
    do_reset();
    beat(2'd3, 128'h5);
    check("err_invalid_id", LINE_W'(bus.err_o), LINE_W'(1));
    step();
    check("err_sticky", LINE_W'(bus.err_o), LINE_W'(1));
    do_reset();
    check("err_cleared", LINE_W'(bus.err_o), '0);

    // Error: id switch mid-line; stray beat stored, line keeps id 0
    alloc(2'd0);
    alloc(2'd1);
    lc = rand_line();
    line_sb.push_back('{id: 2'd0, data: lc});
    dealloc_sb.push_back(2'd0);
    beat(2'd0, lc[0*BEAT_W +: BEAT_W]);
    beat(2'd0, lc[1*BEAT_W +: BEAT_W]);
    check("switch_err_before", LINE_W'(bus.err_o), '0);
    beat(2'd1, lc[2*BEAT_W +: BEAT_W]);
    beat(2'd0, lc[3*BEAT_W +: BEAT_W]);
    check("switch_err", LINE_W'(bus.err_o), LINE_W'(1));
    check("switch_line_id", LINE_W'(bus.line_id_o), '0);
    step();
    step();
    check("switch_valid", LINE_W'(bus.mshr_bank_valid_o), LINE_W'(4'b0010));

    // Error: double alloc of id 0
    do_reset();
    alloc(2'd0);
    check("dbl_err_before", LINE_W'(bus.err_o), '0);
    alloc(2'd0);
    check("dbl_err", LINE_W'(bus.err_o), LINE_W'(1));
    check("dbl_valid", LINE_W'(bus.mshr_bank_valid_o), LINE_W'(4'b0001));

    // Reset mid-line discards the partial line, then a fresh refill completes
    do_reset();
    alloc(2'd2);
    beat(2'd2, 128'h1111);
    beat(2'd2, 128'h2222);
    rst = 1'b0;
    step();
    check("mid_rst_valid", LINE_W'(bus.mshr_bank_valid_o), '0);
    check("mid_rst_line_vld", LINE_W'(bus.line_vld_o), '0);
    check("mid_rst_dealloc", LINE_W'(bus.dealloc_vld_o), '0);
    check("mid_rst_err", LINE_W'(bus.err_o), '0);
    check("mid_rst_data", bus.line_data_o, '0);
    rst = 1'b1;
    alloc(2'd2);
    refill(2'd2, rand_line());
    check("fresh_line_vld", LINE_W'(bus.line_vld_o), LINE_W'(1));
    step();
    check("fresh_dealloc", LINE_W'(bus.dealloc_vld_o), LINE_W'(1));
    step();
    check("fresh_err", LINE_W'(bus.err_o), '0);

    check("sb_line_left", LINE_W'(line_sb.size()), '0);
    check("sb_dealloc_left", LINE_W'(dealloc_sb.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
